// File: rtl/seg7_scroll_scan_if.sv
// Signal bundle between the switch/register side and the 7-segment display block.
// The master drives the message and scroll controls; the slave (the display
// block) returns the segment/anode pins and the current rotation index.
// When SEG7_DIM_EN is defined the bundle also carries the dim[1:0] brightness input.
interface seg7_scroll_scan_if #(
   parameter int NUM_DIGITS = 4,
   parameter int MSG_LEN    = 4
);
   localparam int PW = $clog2(MSG_LEN);

   logic [4*MSG_LEN-1:0]  msg;
   logic [PW-1:0]         offset;
   logic                  mode;
   logic                  dir;
   logic                  pause;
`ifdef SEG7_DIM_EN
   logic [1:0]            dim;
`endif
   logic [6:0]            SEG7;
   logic [NUM_DIGITS-1:0] AN;
   logic [PW-1:0]         pos;

`ifdef SEG7_DIM_EN
   modport master (output msg, offset, mode, dir, pause, dim, input SEG7, AN, pos);
   modport slave  (input msg, offset, mode, dir, pause, dim, output SEG7, AN, pos);
`else
   modport master (output msg, offset, mode, dir, pause, input SEG7, AN, pos);
   modport slave  (input msg, offset, mode, dir, pause, output SEG7, AN, pos);
`endif
endinterface

// File: rtl/seg7_scroll_scan.sv
// Time-multiplexed 7-segment message display with static or automatic rotation.
// Digit k (AN[k], k=0 leftmost) shows message char (pos+k) mod MSG_LEN.
// pos comes from a static offset (mode=0) or a pausable scroll (mode=1).
// Optional feature macro: SEG7_DIM_EN adds dim[1:0], shortening the portion
// of each digit slot during which the anode is enabled.
module seg7_scroll_scan #(
   parameter int NUM_DIGITS = 4,
   parameter int MSG_LEN    = 4,
   parameter int SCAN_DIV   = 50000,
   parameter int SCROLL_DIV = 25000000
) (
   input  logic                 Clock,
   input  logic                 Resetn,
   seg7_scroll_scan_if.slave    bus
);
   localparam int PW  = $clog2(MSG_LEN);
   localparam int DW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int SCW = $clog2(SCAN_DIV);
   localparam int RCW = $clog2(SCROLL_DIV);
   localparam int SW  = PW + DW + 1;

   localparam logic [SCW-1:0] SCAN_LAST   = SCW'(SCAN_DIV - 1);
   localparam logic [RCW-1:0] SCROLL_LAST = RCW'(SCROLL_DIV - 1);
   localparam logic [DW-1:0]  DIG_LAST    = DW'(NUM_DIGITS - 1);
   localparam logic [PW-1:0]  POS_LAST    = PW'(MSG_LEN - 1);
   localparam logic [PW:0]    OFF_LIMIT   = (PW + 1)'(MSG_LEN);
   localparam logic [SW-1:0]  MSG_LEN_W   = SW'(MSG_LEN);

   typedef enum logic [1:0] {
      ST_STATIC = 2'd0,
      ST_SCROLL = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [PW-1:0]         pos_q, pos_d;
   logic [RCW-1:0]        scroll_cnt_q, scroll_cnt_d;
   logic [SCW-1:0]        scan_cnt;
   logic [DW-1:0]         digit_sel;
   logic [6:0]            seg_q;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [SW-1:0]         char_sum, char_idx;
   logic [3:0]            char_code;
   logic [PW-1:0]         offset_safe, pos_step;

   // Active-low segment patterns, bit order gfedcba.
   function automatic logic [6:0] seg7_decode(input logic [3:0] code);
      case (code)
         4'h0: seg7_decode = 7'h40;
         4'h1: seg7_decode = 7'h79;
         4'h2: seg7_decode = 7'h24;
         4'h3: seg7_decode = 7'h30;
         4'h4: seg7_decode = 7'h19;
         4'h5: seg7_decode = 7'h12;
         4'h6: seg7_decode = 7'h02;
         4'h7: seg7_decode = 7'h78;
         4'h8: seg7_decode = 7'h00;
         4'h9: seg7_decode = 7'h10;
         4'hA: seg7_decode = 7'h08;
         4'hB: seg7_decode = 7'h03;
         4'hC: seg7_decode = 7'h46;
         4'hD: seg7_decode = 7'h21;
         4'hE: seg7_decode = 7'h06;
         default: seg7_decode = 7'h0E;
      endcase
   endfunction

   // Digit slot timer: advances digit_sel once per SCAN_DIV clocks, in every state.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         scan_cnt  <= '0;
         digit_sel <= '0;
      end else if (scan_cnt == SCAN_LAST) begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         scan_cnt  <= '0;
         digit_sel <= (digit_sel == DIG_LAST) ? '0 : digit_sel + 1'b1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   // Character shown on the currently selected digit, plus the anode pattern for it.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      char_sum  = SW'(pos_q) + SW'(digit_sel);
      char_idx  = char_sum % MSG_LEN_W;
      char_code = bus.msg[{char_idx, 2'b00} +: 4];
      an_d      = ~(NUM_DIGITS'(1) << digit_sel);
`ifdef SEG7_DIM_EN
      if ((32'(scan_cnt) << 2) >= ((32'(bus.dim) + 32'd1) * 32'(SCAN_DIV) & ~32'd3))
         an_d = '1;
`endif
   end

   // Output pins: anodes and segments update together one clock after the selection.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         seg_q <= 7'h7F;
         an_q  <= '1;
      end else begin
         seg_q <= seg7_decode(char_code);
         an_q  <= an_d;
      end
   end

   // Rotation candidates: validated static offset and one scroll step in the chosen direction.
   always_comb begin
      offset_safe = ({1'b0, bus.offset} < OFF_LIMIT) ? bus.offset : '0;
      if (bus.dir)
         pos_step = (pos_q == '0) ? POS_LAST : pos_q - 1'b1;
      else
         pos_step = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
   end

   // Rotation FSM next state: mode wins over pause; HOLD freezes both pos and the scroll count.
   always_comb begin
      state_d      = state_q;
      pos_d        = pos_q;
      scroll_cnt_d = scroll_cnt_q;
      case (state_q)
         ST_STATIC: begin
            scroll_cnt_d = '0;
            if (bus.mode) state_d = ST_SCROLL;
            else          pos_d   = offset_safe;
         end
         ST_SCROLL: begin
            if (!bus.mode) begin
               state_d      = ST_STATIC;
               pos_d        = offset_safe;
               scroll_cnt_d = '0;
            end else if (bus.pause) begin
               state_d = ST_HOLD;
            end else if (scroll_cnt_q == SCROLL_LAST) begin
               scroll_cnt_d = '0;
               pos_d        = pos_step;
            end else begin
               scroll_cnt_d = scroll_cnt_q + 1'b1;
            end
         end
         ST_HOLD: begin
            if (!bus.mode) begin
               state_d      = ST_STATIC;
               pos_d        = offset_safe;
               scroll_cnt_d = '0;
            end else if (!bus.pause) begin
               state_d = ST_SCROLL;
            end
         end
         default: begin
            state_d      = ST_STATIC;
            pos_d        = '0;
            scroll_cnt_d = '0;
         end
      endcase
   end

   // Rotation FSM state register.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q      <= ST_STATIC;
         pos_q        <= '0;
         scroll_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         pos_q        <= pos_d;
         scroll_cnt_q <= scroll_cnt_d;
      end
   end

   assign bus.SEG7 = seg_q;
   assign bus.AN   = an_q;
   assign bus.pos  = pos_q;
endmodule

// File: tb/tb_seg7_scroll_scan.sv
// Bench for seg7_scroll_scan: a cycle-count based reference model checked every
// clock, plus hand-computed literal expectations for the directed scenarios.
module tb_seg7_scroll_scan;
   localparam int ND = 4;
   localparam int ML = 4;
   localparam int SD = 2;
   localparam int RD = 8;

   logic Clock;
   logic Resetn;
   int   checks = 0;
   int   errors = 0;

   seg7_scroll_scan_if #(.NUM_DIGITS(ND), .MSG_LEN(ML)) bus ();

   seg7_scroll_scan #(
      .NUM_DIGITS(ND), .MSG_LEN(ML), .SCAN_DIV(SD), .SCROLL_DIV(RD)
   ) dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .bus    (bus)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: digit slot from clocks since reset, pos from mode/pause history.
   logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   int         n_clk      = 0;
   int         m_pos      = 0;
   int         m_cnt      = 0;
   bit         mode_prev  = 1'b0;
   bit         pause_prev = 1'b0;
   logic [6:0] m_seg      = 7'h7F;
   logic [3:0] m_an       = 4'hF;

   always @(posedge Clock or negedge Resetn) begin
      int         dsel, slot, idx;
      logic [15:0] shifted;
      if (!Resetn) begin
         n_clk = 0; m_pos = 0; m_cnt = 0;
         mode_prev = 1'b0; pause_prev = 1'b0;
         m_seg = 7'h7F; m_an = 4'hF;
      end else begin
         dsel    = (n_clk / SD) % ND;
         slot    = n_clk % SD;
         idx     = (m_pos + dsel) % ML;
         shifted = bus.msg >> (4 * idx);
         m_seg   = dec_tab[shifted[3:0]];
         m_an    = 4'hF;
         m_an[dsel] = 1'b0;
`ifdef SEG7_DIM_EN
         if (slot >= ((int'(bus.dim) + 1) * SD) / 4) m_an = 4'hF;
`else
         if (slot < 0) m_an = 4'hF;
`endif
         if (!bus.mode) begin
            m_pos = (int'(bus.offset) < ML) ? int'(bus.offset) : 0;
            m_cnt = 0;
         end else if (!bus.pause && mode_prev && !pause_prev) begin
            if (m_cnt == RD - 1) begin
               m_cnt = 0;
               m_pos = bus.dir ? (m_pos + ML - 1) % ML : (m_pos + 1) % ML;
            end else begin
               m_cnt++;
            end
         end
         mode_prev  = bus.mode;
         pause_prev = bus.pause;
         n_clk++;
      end
   end

   // Compare process: DUT outputs against the model on every falling edge out of reset.
   always @(negedge Clock) begin
      if (Resetn === 1'b1) begin
         check("model_seg", 32'(bus.SEG7), 32'(m_seg));
         check("model_an",  32'(bus.AN),   32'(m_an));
         check("model_pos", 32'(bus.pos),  32'(m_pos));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge Clock);
   endtask

   // Align to the first clock of digit 0 (AN goes 7 -> E), bounded.
   task automatic wait_digit0();
      int guard;
      guard = 0;
      while (bus.AN !== 4'h7 && guard < 16) begin tick(1); guard++; end
      while (bus.AN !== 4'hE && guard < 16) begin tick(1); guard++; end
      check("align_timeout", 32'(guard < 16), 32'd1);
   endtask

   logic [6:0] seq_off1 [4] = '{7'h06, 7'h79, 7'h40, 7'h21};
   logic [6:0] seq_off3 [4] = '{7'h40, 7'h21, 7'h06, 7'h79};
   logic [6:0] seq_off0 [4] = '{7'h21, 7'h06, 7'h79, 7'h40};

   initial begin
      Resetn     = 1'b0;
      bus.msg    = 16'h01ED;
      bus.offset = '0;
      bus.mode   = 1'b0;
      bus.dir    = 1'b0;
      bus.pause  = 1'b0;
`ifdef SEG7_DIM_EN
      bus.dim    = 2'd3;
`endif
      // Reset held.
      tick(3);
      check("rst_seg", 32'(bus.SEG7), 32'h7F);
      check("rst_an",  32'(bus.AN),   32'hF);
      check("rst_pos", 32'(bus.pos),  32'h0);
      Resetn = 1'b1;

      // Static offset 0: d E 1 0, two clocks per digit, first clock after release.
      for (int i = 0; i < 8; i++) begin
         tick(1);
         check("scan0_an",  32'(bus.AN),   32'(~(4'h1 << (i / 2)) & 4'hF));
         check("scan0_seg", 32'(bus.SEG7), 32'(seq_off0[i / 2]));
      end

      // Static offset 1 then 3.
      bus.offset = 2'd1;
      tick(2);
      wait_digit0();
      for (int k = 0; k < 4; k++) begin
         check("off1_seg", 32'(bus.SEG7), 32'(seq_off1[k]));
         tick(2);
      end
      bus.offset = 2'd3;
      tick(2);
      wait_digit0();
      for (int k = 0; k < 4; k++) begin
         check("off3_seg", 32'(bus.SEG7), 32'(seq_off3[k]));
         tick(2);
      end

      // Auto scroll up from 3 with wrap to 0, then 1.
      bus.mode = 1'b1;
      tick(8); check("up_before", 32'(bus.pos), 32'd3);
      tick(1); check("up_wrap",   32'(bus.pos), 32'd0);
      tick(8); check("up_next",   32'(bus.pos), 32'd1);

      // Scroll down through 0 and wrap to 3.
      bus.dir = 1'b1;
      tick(7); check("dn_before", 32'(bus.pos), 32'd1);
      tick(1); check("dn_step",   32'(bus.pos), 32'd0);
      tick(8); check("dn_wrap",   32'(bus.pos), 32'd3);

      // Pause mid-interval at count 3; resume finishes the remaining count.
      tick(3);
      bus.pause = 1'b1;
      tick(20); check("pause_hold", 32'(bus.pos), 32'd3);
      bus.pause = 1'b0;
      tick(5); check("resume_before", 32'(bus.pos), 32'd3);
      tick(1); check("resume_step",   32'(bus.pos), 32'd2);

      // Back to static: offset reloads on the next clock.
      bus.mode   = 1'b0;
      bus.offset = 2'd2;
      tick(1); check("reload", 32'(bus.pos), 32'd2);
      bus.mode = 1'b1;
      bus.dir  = 1'b0;
      tick(12);

      // Asynchronous reset mid-scroll.
      #1 Resetn = 1'b0;
      #1;
      check("arst_pos", 32'(bus.pos),  32'd0);
      check("arst_an",  32'(bus.AN),   32'hF);
      check("arst_seg", 32'(bus.SEG7), 32'h7F);
      tick(2);
`ifdef SEG7_DIM_EN
      bus.dim = 2'd0;
      Resetn  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         check("dim0_an", 32'(bus.AN), 32'hF);
      end
      bus.dim = 2'd3;
`else
      Resetn = 1'b1;
      tick(1);
      check("post_rst_an",  32'(bus.AN),   32'hE);
      check("post_rst_seg", 32'(bus.SEG7), 32'h21);
`endif
      tick(10);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end
endmodule
